cic_rate_ctrl: RTL and testbench
================================

# cic_rate_ctrl

Sequencing controller for one `cic_decim` instance in the RX DSP chain. It generates the input-sample strobe (`nd`) from `dspclk` and owns the decimator's `sclr`/`rate_we`/`rate` pins. It accepts host rate-change requests over a valid/ready handshake and applies each one at an output-sample boundary via a clear/load/settle sequence. It gates the decimator output so downstream blocks never see samples from the transient after a rate change.

## Interface
Parameters:
- `ND_DIV`, 4: `dspclk` cycles per input sample (128 MHz / 4 = 32 MHz); must be at least 2.
- `RATE_DEFAULT`, 13'd4: rate loaded after reset.
- `RATE_MIN`, 13'd4: lowest legal rate.
- `RATE_MAX`, 13'd4095: highest legal rate.
- `SETTLE_OUTPUTS`, 3: decimator outputs discarded after each load.
- `DRAIN_MAX`, 16384: DRAIN timeout in cycles.

Ports:
- `dspclk` in 1: DSP clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cfg_rate` in 13: requested decimation rate.
- `cfg_valid` in 1: request valid.
- `cfg_ready` out 1: request accepted when high together with `cfg_valid`.
- `cfg_err` out 1: one-cycle pulse when an accepted rate is out of range.
- `busy` out 1: high whenever state ≠ RUN.
- `cic_nd` out 1: to `cic_decim.nd`.
- `cic_rfd` in 1: from `cic_decim.rfd`.
- `cic_sclr` out 1: to `cic_decim.sclr`.
- `cic_rate_we` out 1: to `cic_decim.rate_we`.
- `cic_rate` out 13: to `cic_decim.rate`.
- `cic_rdy` in 1: from `cic_decim.rdy`.
- `cic_dout` in 16: from `cic_decim.dout`.
- `dout` out 16: gated sample, registered.
- `dout_valid` out 1: one cycle per delivered sample.

## Operation
- States: CLEAR, LOAD, SETTLE, RUN, DRAIN. Reset state is CLEAR.
- Strobe counter: `sc` counts 0..ND_DIV-1, free-running in every state, resets to 0.
  - `cic_nd = (sc==0) & cic_rfd & state∈{SETTLE,RUN,DRAIN}`.
  - When a strobe is suppressed, that input sample is dropped. The counter does not stall.
- CLEAR (1 cycle): `cic_sclr=1`. `cic_rate` is loaded from `pending` on the exit edge. Next state is LOAD.
- LOAD (1 cycle): `cic_rate_we=1` and `cic_rate` is stable. Clear the settle counter. Next state is SETTLE.
- SETTLE: count `cic_rdy` pulses and force `dout_valid=0`. When the count reaches SETTLE_OUTPUTS, go to RUN on the same edge as the last discarded `cic_rdy`.
- RUN:
  - `cfg_ready=1`.
  - `dout<=cic_dout` and `dout_valid<=cic_rdy`.
  - On the handshake with `cfg_rate` in [RATE_MIN, RATE_MAX]: `pending<=cfg_rate` and go to DRAIN.
  - On the handshake with an out-of-range `cfg_rate`: pulse `cfg_err` on the next cycle, stay in RUN, and leave `cic_rate` unchanged.
- DRAIN:
  - Output passthrough continues as in RUN.
  - On the first `cic_rdy`, deliver that sample, then go to CLEAR.
  - If no `cic_rdy` arrives within DRAIN_MAX cycles, go to CLEAR anyway.
- `cfg_ready=0` in every state except RUN. Requests are not queued; the host holds `cfg_valid` until it is accepted.
- `pending` resets to RATE_DEFAULT, so the post-reset sequence is CLEAR → LOAD → SETTLE → RUN at the default rate.

## Timing
- Reset values:
  - `cic_sclr=1` (state CLEAR).
  - `cic_rate=RATE_DEFAULT`.
  - `cfg_ready`, `cfg_err`, `cic_rate_we`, `cic_nd`, and `dout_valid` are 0.
  - `dout` is 0.
  - `busy` is 1.
- After `reset_n` rises:
  - Cycle 0: CLEAR (`sclr=1`).
  - Cycle 1: LOAD (`rate_we=1`).
  - Cycle 2: SETTLE. The first `cic_nd` is issued in the first SETTLE cycle with `sc==0`.
- `cic_rate` never changes while `cic_rate_we=1`. It is constant from LOAD until the next CLEAR exit.
- `dout`/`dout_valid` lag `cic_dout`/`cic_rdy` by exactly 1 cycle.
- A `cic_rdy` in the cycle of the RUN→DRAIN transition is delivered.
- `cfg_err` is asserted 1 cycle after the rejecting handshake and lasts 1 cycle.
- If `reset_n` is asserted mid-sequence, the block returns asynchronously to reset values and any pending rate is lost.
- The DRAIN timeout counter is 15 bits, cleared on DRAIN entry. The timeout fires at count DRAIN_MAX-1.

## Structure
- Package `cic_ctrl_pkg` holds:
  - the state enum;
  - `CIC_RATE_W=13` and `CIC_DOUT_W=16`;
  - `RATE_MIN`/`RATE_MAX` defaults.
- Sub-module `nd_strobe_gen` contains the strobe counter and enable gating, with ports `dspclk`, `reset_n`, `en`, `rfd`, and `nd`.
- The FSM, `pending` register, settle and timeout counters, and output register all live in the top module.

## Test plan
- Reset release with a behavioral decimator model:
  - Cycle 0 `sclr=1`; cycle 1 `rate_we=1` with `rate=4`.
  - `cic_nd` every 4th cycle.
  - The first 3 `rdy` are suppressed and the 4th appears as `dout_valid`.
- In RUN, request `cfg_rate=16`:
  - `cfg_ready` drops.
  - The next `rdy` sample is delivered, then `sclr` and `rate_we` appear with `cic_rate=16`.
  - 3 outputs are discarded, then `busy=0`.
- Request `cfg_rate=2` and, separately, `cfg_rate=5000`: `cfg_err` pulses 1 cycle after the handshake, `cic_rate` stays unchanged, and there is no `sclr`.
- Hold `cic_rfd=0` and issue a request: no `nd` and no `rdy`, so DRAIN exits after 16384 cycles and the CLEAR/LOAD sequence runs.
- Assert `reset_n=0` during SETTLE: outputs take their reset values immediately and the post-reset sequence reloads rate 4.
- Drive `cic_rdy` in the same cycle as an accepted request: that sample appears on `dout` 1 cycle later with `dout_valid=1`.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// rtl/cic_ctrl_pkg.sv - shared types, widths and rate limits for the CIC rate controller
package cic_ctrl_pkg;

  localparam int CIC_RATE_W = 13;
  localparam int CIC_DOUT_W = 16;

  localparam logic [CIC_RATE_W-1:0] RATE_MIN_DEFAULT = 13'd4;
  localparam logic [CIC_RATE_W-1:0] RATE_MAX_DEFAULT = 13'd4095;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN
  } ctrl_state_e;

  function automatic logic rate_in_range(input logic [CIC_RATE_W-1:0] rate,
                                         input logic [CIC_RATE_W-1:0] lo,
                                         input logic [CIC_RATE_W-1:0] hi);
    return (rate >= lo) && (rate <= hi);
  endfunction

endpackage

// File: rtl/cic_rate_ctrl_if.sv
// rtl/cic_rate_ctrl_if.sv - host request handshake plus cic_decim control/data pins
interface cic_rate_ctrl_if;
  import cic_ctrl_pkg::*;

  logic [CIC_RATE_W-1:0] cfg_rate;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_err;
  logic                  busy;
  logic                  cic_nd;
  logic                  cic_rfd;
  logic                  cic_sclr;
  logic                  cic_rate_we;
  logic [CIC_RATE_W-1:0] cic_rate;
  logic                  cic_rdy;
  logic [CIC_DOUT_W-1:0] cic_dout;
  logic [CIC_DOUT_W-1:0] dout;
  logic                  dout_valid;

  // master is the controller; slave is the host plus decimator side
  modport master (
    input  cfg_rate, cfg_valid, cic_rfd, cic_rdy, cic_dout,
    output cfg_ready, cfg_err, busy, cic_nd, cic_sclr, cic_rate_we, cic_rate,
           dout, dout_valid
  );

  modport slave (
    output cfg_rate, cfg_valid, cic_rfd, cic_rdy, cic_dout,
    input  cfg_ready, cfg_err, busy, cic_nd, cic_sclr, cic_rate_we, cic_rate,
           dout, dout_valid
  );

endinterface

// File: rtl/nd_strobe_gen.sv
// rtl/nd_strobe_gen.sv - free-running input-sample strobe, gated by enable and decimator rfd
module nd_strobe_gen #(
  parameter int ND_DIV = 4
) (
  input  logic dspclk,
  input  logic reset_n,
  input  logic en,
  input  logic rfd,
  output logic nd
);

  localparam int SC_W = (ND_DIV > 1) ? $clog2(ND_DIV) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(ND_DIV - 1);

  logic [SC_W-1:0] sc_q, sc_d;

  // The counter never stalls: a suppressed strobe simply drops that input sample.
  always_comb begin
    sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
  end

  always_ff @(posedge dspclk or negedge reset_n) begin
    if (!reset_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign nd = (sc_q == '0) & rfd & en;

endmodule

// File: rtl/cic_rate_ctrl.sv
// rtl/cic_rate_ctrl.sv - sequences cic_decim clear/load/settle on rate changes and gates its output
module cic_rate_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int                    ND_DIV         = 4,
  parameter logic [CIC_RATE_W-1:0] RATE_DEFAULT   = 13'd4,
  parameter logic [CIC_RATE_W-1:0] RATE_MIN       = RATE_MIN_DEFAULT,
  parameter logic [CIC_RATE_W-1:0] RATE_MAX       = RATE_MAX_DEFAULT,
  parameter int                    SETTLE_OUTPUTS = 3,
  parameter int                    DRAIN_MAX      = 16384
) (
  input  logic           dspclk,
  input  logic           reset_n,
  cic_rate_ctrl_if.master bus
);

  localparam int ST_W = (SETTLE_OUTPUTS > 1) ? $clog2(SETTLE_OUTPUTS + 1) : 1;
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_OUTPUTS - 1);
  localparam logic [14:0]     DRAIN_LAST  = 15'(DRAIN_MAX - 1);

  ctrl_state_e           state_q, state_d;
  logic [CIC_RATE_W-1:0] pending_q, pending_d;
  logic [CIC_RATE_W-1:0] rate_q, rate_d;
  logic [ST_W-1:0]       settle_q, settle_d;
  logic [14:0]           drain_q, drain_d;
  logic [CIC_DOUT_W-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  handshake;
  logic                  rate_ok;
  logic                  nd_en;
  logic                  nd;

  assign handshake = bus.cfg_valid & (state_q == ST_RUN);
  assign rate_ok   = rate_in_range(bus.cfg_rate, RATE_MIN, RATE_MAX);
  assign nd_en     = (state_q == ST_SETTLE) | (state_q == ST_RUN) | (state_q == ST_DRAIN);

  nd_strobe_gen #(
    .ND_DIV (ND_DIV)
  ) u_nd_strobe_gen (
    .dspclk  (dspclk),
    .reset_n (reset_n),
    .en      (nd_en),
    .rfd     (bus.cic_rfd),
    .nd      (nd)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rate_d       = rate_q;
    settle_d     = settle_q;
    drain_d      = '0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    cfg_err_d    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        rate_d  = pending_q;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      // Outputs here come from the transient after the load and are discarded.
      ST_SETTLE: begin
        if (bus.cic_rdy) begin
          if (settle_q == SETTLE_LAST) begin
            state_d = ST_RUN;
          end else begin
            settle_d = settle_q + ST_W'(1);
          end
        end
      end
      ST_RUN: begin
        dout_d       = bus.cic_dout;
        dout_valid_d = bus.cic_rdy;
        if (handshake) begin
          if (rate_ok) begin
            pending_d = bus.cfg_rate;
            state_d   = ST_DRAIN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      // Wait for one output boundary so the last sample at the old rate is delivered.
      ST_DRAIN: begin
        dout_d       = bus.cic_dout;
        dout_valid_d = bus.cic_rdy;
        drain_d      = drain_q + 15'd1;
        if (bus.cic_rdy || (drain_q == DRAIN_LAST)) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge dspclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      pending_q    <= RATE_DEFAULT;
      rate_q       <= RATE_DEFAULT;
      settle_q     <= '0;
      drain_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rate_q       <= rate_d;
      settle_q     <= settle_d;
      drain_q      <= drain_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.cfg_ready   = (state_q == ST_RUN);
  assign bus.busy        = (state_q != ST_RUN);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.cic_nd      = nd;
  assign bus.cic_sclr    = (state_q == ST_CLEAR);
  assign bus.cic_rate_we = (state_q == ST_LOAD);
  assign bus.cic_rate    = rate_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb/tb_cic_rate_ctrl.sv - randomized bench for cic_rate_ctrl with a behavioural decimator and delivery scoreboard
module tb_cic_rate_ctrl;
  import cic_ctrl_pkg::*;

  localparam int ND_DIV    = 4;
  localparam int SETTLE    = 3;
  localparam int DRAIN_MAX = 16384;

  logic dspclk  = 1'b0;
  logic reset_n = 1'b0;

  cic_rate_ctrl_if bus ();

  cic_rate_ctrl #(
    .ND_DIV         (ND_DIV),
    .RATE_DEFAULT   (13'd4),
    .RATE_MIN       (13'd4),
    .RATE_MAX       (13'd4095),
    .SETTLE_OUTPUTS (SETTLE),
    .DRAIN_MAX      (DRAIN_MAX)
  ) dut (
    .dspclk  (dspclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 dspclk = ~dspclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decimator model: one output per `rate` accepted input strobes, one cycle after the last.
  logic        rdy_m    = 1'b0;
  logic [15:0] dout_m   = '0;
  int          mcnt     = 0;
  int          rate_m   = 4;
  logic        inj_rdy  = 1'b0;
  logic [15:0] inj_dout = '0;
  logic        rfd_en   = 1'b1;

  always @(posedge dspclk) begin
    rdy_m <= 1'b0;
    if (bus.cic_sclr) begin
      mcnt <= 0;
    end else if (bus.cic_rate_we) begin
      rate_m <= int'(bus.cic_rate);
    end else if (bus.cic_nd) begin
      if (mcnt + 1 >= rate_m) begin
        mcnt   <= 0;
        rdy_m  <= 1'b1;
        dout_m <= 16'($urandom);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  assign bus.cic_rdy  = rdy_m | inj_rdy;
  assign bus.cic_dout = inj_rdy ? inj_dout : dout_m;
  assign bus.cic_rfd  = rfd_en;

  // Scoreboard: after each load the first SETTLE outputs are hidden, every later one is
  // delivered exactly one cycle after it appears; the rate is frozen from load to clear.
  int          since_load  = 0;
  bit          exp_v       = 1'b0;
  logic [15:0] exp_d       = '0;
  bit          rate_locked = 1'b0;
  logic [12:0] locked_rate = '0;
  int          n_delivered = 0;

  always @(negedge dspclk) begin
    if (!reset_n) begin
      exp_v       = 1'b0;
      since_load  = 0;
      rate_locked = 1'b0;
    end else begin
      check_eq("dout_valid_lag", bus.dout_valid, exp_v);
      if (exp_v) begin
        check_eq("dout_data", bus.dout, exp_d);
        n_delivered++;
      end
      if (bus.cic_nd) check_eq("nd_needs_rfd", bus.cic_rfd, 1);
      if (bus.cic_sclr) rate_locked = 1'b0;
      if (bus.cic_rate_we) begin
        since_load  = 0;
        rate_locked = 1'b1;
        locked_rate = bus.cic_rate;
      end else if (rate_locked) begin
        check_eq("rate_stable", bus.cic_rate, locked_rate);
      end
      exp_v = 1'b0;
      if (bus.cic_rdy) begin
        if (since_load >= SETTLE) begin
          exp_v = 1'b1;
          exp_d = bus.cic_dout;
        end
        since_load++;
      end
    end
  end

  task automatic tick();
    @(posedge dspclk);
    #2;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, bus.busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sclr"}, bus.cic_sclr, 1);
    check_eq({tag, "_rate"}, bus.cic_rate, 4);
    check_eq({tag, "_ready"}, bus.cfg_ready, 0);
    check_eq({tag, "_err"}, bus.cfg_err, 0);
    check_eq({tag, "_we"}, bus.cic_rate_we, 0);
    check_eq({tag, "_nd"}, bus.cic_nd, 0);
    check_eq({tag, "_dvalid"}, bus.dout_valid, 0);
    check_eq({tag, "_dout"}, bus.dout, 0);
    check_eq({tag, "_busy"}, bus.busy, 1);
  endtask

  task automatic check_release_sequence(input string tag);
    int first_nd = -1;
    int last_nd  = -1;
    for (int k = 0; k < 41; k++) begin
      if (k == 0) check_eq({tag, "_c0_sclr"}, bus.cic_sclr, 1);
      if (k == 1) begin
        check_eq({tag, "_c1_we"}, bus.cic_rate_we, 1);
        check_eq({tag, "_c1_rate"}, bus.cic_rate, 4);
      end
      if (k == 2) begin
        check_eq({tag, "_c2_sclr"}, bus.cic_sclr, 0);
        check_eq({tag, "_c2_we"}, bus.cic_rate_we, 0);
      end
      if (bus.cic_nd) begin
        if (first_nd < 0) first_nd = k;
        else check_eq({tag, "_nd_spacing"}, k - last_nd, ND_DIV);
        last_nd = k;
      end
      tick();
    end
    check_eq({tag, "_first_nd"}, first_nd, 4);
  endtask

  task automatic do_request(input logic [12:0] r, input bit inj);
    logic [12:0] old_rate;
    bit          ok;
    bit          saw_sclr = 1'b0;
    int          n = 0;
    ok = (r >= 13'd4) && (r <= 13'd4095);
    wait_idle(4000, "idle_before_req");
    check_eq("ready_in_run", bus.cfg_ready, 1);
    old_rate      = bus.cic_rate;
    bus.cfg_rate  = r;
    bus.cfg_valid = 1'b1;
    if (inj) begin
      inj_rdy  = 1'b1;
      inj_dout = 16'($urandom);
    end
    tick();
    bus.cfg_valid = 1'b0;
    inj_rdy       = 1'b0;
    if (inj) begin
      check_eq("hs_rdy_valid", bus.dout_valid, 1);
      check_eq("hs_rdy_data", bus.dout, inj_dout);
    end
    if (ok) begin
      check_eq("ready_drops", bus.cfg_ready, 0);
      check_eq("busy_drain", bus.busy, 1);
      while (!bus.cic_sclr && n < 2000) begin
        tick();
        n++;
      end
      check_eq("drain_to_clear", bus.cic_sclr, 1);
      check_eq("drain_delivers", bus.dout_valid, 1);
      tick();
      check_eq("load_we", bus.cic_rate_we, 1);
      check_eq("load_rate", bus.cic_rate, r);
      wait_idle(4000, "settle_to_run");
    end else begin
      check_eq("err_pulse", bus.cfg_err, 1);
      check_eq("err_stays_run", bus.busy, 0);
      check_eq("err_rate_same", bus.cic_rate, old_rate);
      tick();
      check_eq("err_one_cycle", bus.cfg_err, 0);
      repeat (40) begin
        if (bus.cic_sclr) saw_sclr = 1'b1;
        tick();
      end
      check_eq("err_no_sclr", saw_sclr, 0);
      check_eq("err_rate_kept", bus.cic_rate, old_rate);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          nd_seen;
    int          sel;
    logic [12:0] r;

    bus.cfg_valid = 1'b0;
    bus.cfg_rate  = '0;

    #12;
    check_reset_outputs("reset");

    @(posedge dspclk);
    #2;
    reset_n = 1'b1;
    check_release_sequence("por");
    wait_idle(400, "por_settle");
    check_eq("por_none_delivered", n_delivered, 0);
    n = 0;
    while (!bus.dout_valid && n < 200) begin
      tick();
      n++;
    end
    check_eq("por_fourth_rdy", bus.dout_valid, 1);

    do_request(13'd16, 1'b0);
    do_request(13'd2, 1'b0);
    do_request(13'd5000, 1'b0);
    do_request(13'd8, 1'b1);
    do_request(13'd3, 1'b0);
    do_request(13'd4096, 1'b0);
    do_request(13'd4, 1'b0);

    for (int i = 0; i < 10; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      r = 13'($urandom_range(4, 24));
      else if (sel < 8) r = 13'($urandom_range(0, 3));
      else              r = 13'($urandom_range(4096, 8191));
      do_request(r, 1'($urandom_range(0, 1)));
    end

    // No input strobes at all: DRAIN must give up on its timeout.
    wait_idle(4000, "idle_before_timeout");
    rfd_en = 1'b0;
    repeat (8) tick();
    bus.cfg_rate  = 13'd12;
    bus.cfg_valid = 1'b1;
    check_eq("timeout_ready", bus.cfg_ready, 1);
    tick();
    bus.cfg_valid = 1'b0;
    n       = 0;
    nd_seen = 0;
    while (!bus.cic_sclr && n < DRAIN_MAX + 100) begin
      if (bus.cic_nd) nd_seen++;
      tick();
      n++;
    end
    check_eq("timeout_cycles", n, DRAIN_MAX);
    check_eq("timeout_no_nd", nd_seen, 0);
    check_eq("timeout_no_valid", bus.dout_valid, 0);
    tick();
    check_eq("timeout_load_we", bus.cic_rate_we, 1);
    check_eq("timeout_load_rate", bus.cic_rate, 12);
    rfd_en = 1'b1;
    wait_idle(4000, "timeout_settle");

    // Reset while settling at a non-default rate.
    wait_idle(4000, "idle_before_reset");
    bus.cfg_rate  = 13'd16;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    n = 0;
    while (!bus.cic_rate_we && n < 2000) begin
      tick();
      n++;
    end
    check_eq("pre_reset_load_rate", bus.cic_rate, 16);
    repeat (5) tick();
    check_eq("pre_reset_settling", bus.busy, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    tick();
    reset_n = 1'b1;
    check_release_sequence("rerun");
    wait_idle(400, "rerun_settle");
    do_request(13'd5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
